rca_pipe_addsub: RTL and testbench
==================================

// Module: rca_pipe_addsub
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 4-bit RCA.
//  Splits a WIDTH-bit operation into CHUNK-bit slices, one slice per pipeline stage.
//  Adds a carry/borrow input, a subtract mode, a signed-overflow flag and valid/ready flow control.
//  Used as the arithmetic datapath element feeding the ALU/accumulator blocks.
// PARAMETERS
//  WIDTH   16  operand/result width; WIDTH % CHUNK == 0, WIDTH >= 2
//  CHUNK   4   bits resolved per stage; derived localparam STAGES = WIDTH/CHUNK = latency
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  reset_n    in   1      synchronous reset, active-low
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+ci ; 1: a-b-ci
//  out_valid  out  1      result beat present
//  out_ready  in   1      downstream accepts result this cycle
//  s          out  WIDTH  sum/difference, modulo 2^WIDTH
//  co         out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): all stage valid bits, out_valid, s, co, ovf -> 0. In-flight beats discarded.
//  - Accept: beat transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
//  - Global advance = !out_valid || out_ready; in_ready = advance (combinational from out_ready/out_valid).
//  - When advance=0, every stage register holds; s/co/ovf/out_valid stable until consumed.
//  - Effective operands: B' = sub ? ~b : b ; c0 = ci ^ sub.
//  - Stage k (0..STAGES-1): adds slice k of A and B' with carry from stage k-1 (stage 0: c0).
//    Upper slices of A/B' skewed through delay registers; finished lower result slices delayed so that
//    all slices of one beat exit together.
//  - Latency: beat accepted at edge N appears with out_valid=1 after edge N+STAGES (absent stalls).
//  - Throughput: one beat/cycle; bubbles (in_valid=0) propagate as valid=0, never as results.
//  - co = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//  - Order preserved; no beat dropped or duplicated under any in_valid/out_ready pattern.
//  - Simultaneous accept and emit in one cycle is legal and required at full rate.
//  - Inputs a/b/ci/sub sampled only on accept; changes while in_ready=0 are ignored.
//  - Reset mid-operation: flush has priority over advance; first cycle after release out_valid=0, in_ready=1.
// STRUCTURE
//  - Shared package rca_pkg: default WIDTH/CHUNK constants, function computing STAGES,
//    elaboration check macro for WIDTH % CHUNK.
//  - Sub-module rca_chunk #(W): combinational W-bit ripple-carry slice (a, b, ci -> s, co, c_msb_in),
//    built from full-adder cells; instantiated once per stage via generate.
//  - Top holds skew/deskew registers, per-stage valid bits and the advance logic.
// TESTING (WIDTH=16, CHUNK=4, latency 4)
//  1. reset_n=0 two cycles -> out_valid=0, s=0, co=0, ovf=0, in_ready=1 after release.
//  2. a=0x00FF, b=0x0001, ci=0, sub=0 -> s=0x0100, co=0, ovf=0 exactly 4 cycles after accept.
//  3. 0xFFFF+0x0001 -> s=0x0000, co=1, ovf=0; 0x7FFF+0x0001 -> s=0x8000, co=0, ovf=1.
//  4. sub: 0x0005-0x0007 -> s=0xFFFE, co=0, ovf=0; 0x8000-0x0001 -> s=0x7FFF, co=1, ovf=1;
//     0x0010-0x0001 with ci=1 -> s=0x000E.
//  5. stream 16 random beats, out_ready toggled every cycle, in_valid random -> results in order,
//     match reference model, in_ready=0 exactly when out_valid && !out_ready, output stable during stall.
//  6. accept 3 beats, assert reset_n=0 one cycle -> out_valid=0 from next edge; no stale result ever emitted.

Source files
------------

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared geometry constants and helpers for the pipelined ripple-carry adder
`ifndef RCA_PKG_SV
`define RCA_PKG_SV

`define RCA_CHECK_DIVISIBLE(W, C) \
  if ((((W) % (C)) != 0) || ((W) < 2)) begin : g_bad_geometry \
    $error("rca: WIDTH must be >= 2 and a multiple of CHUNK"); \
  end

package rca_pkg;

  localparam int RCA_WIDTH = 16;
  localparam int RCA_CHUNK = 4;

  function automatic int rca_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

`endif

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational W-bit ripple-carry slice built from full-adder cells
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co       = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// rtl/rca_pipe_addsub.sv - pipelined ripple-carry add/sub, one CHUNK-bit slice per stage
module rca_pipe_addsub
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH,
  parameter int CHUNK = RCA_CHUNK
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int STAGES = rca_stages(WIDTH, CHUNK);

  `RCA_CHECK_DIVISIBLE(WIDTH, CHUNK)

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = ci ^ sub;

  // Stage k register layout: {unused B' slices k.., A slices k.. over finished result slices 0..k-1}
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DW = 2 * WIDTH - k * CHUNK;

    logic [DW-1:0]    d_q;
    logic             c_q;
    logic             v_q;
    logic [DW-1:0]    d_in;
    logic             c_in;
    logic             v_in;
    logic [CHUNK-1:0] sum;
    logic             c_out;
    logic [WIDTH-1:0] lo_nxt;

    if (k == 0) begin : g_src
      assign d_in = {b_eff, a};
      assign c_in = c0;
      assign v_in = in_valid;
    end else begin : g_src
      assign d_in = {g_stage[k-1].d_q[DW+CHUNK-1:WIDTH+CHUNK], g_stage[k-1].lo_nxt};
      assign c_in = g_stage[k-1].c_out;
      assign v_in = g_stage[k-1].v_q;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
      end
    end

    always_ff @(posedge clk) begin
      if (adv && v_in) begin
        d_q <= d_in;
        c_q <= c_in;
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic c_msb;
      rca_chunk #(.W(CHUNK)) u_chunk (
        .a        (d_q[k*CHUNK +: CHUNK]),
        .b        (d_q[WIDTH +: CHUNK]),
        .ci       (c_q),
        .s        (sum),
        .co       (c_out),
        .c_msb_in (c_msb)
      );
    end else begin : g_mid
      rca_chunk #(.W(CHUNK)) u_chunk (
        .a        (d_q[k*CHUNK +: CHUNK]),
        .b        (d_q[WIDTH +: CHUNK]),
        .ci       (c_q),
        .s        (sum),
        .co       (c_out),
        .c_msb_in ()
      );
    end

    always_comb begin
      lo_nxt                   = d_q[WIDTH-1:0];
      lo_nxt[k*CHUNK +: CHUNK] = sum;
    end
  end

  // Result registers only reload on a real beat so s/co/ovf keep the last result across bubbles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= g_stage[STAGES-1].v_q;
      if (g_stage[STAGES-1].v_q) begin
        s   <= g_stage[STAGES-1].lo_nxt;
        co  <= g_stage[STAGES-1].c_out;
        ovf <= g_stage[STAGES-1].g_last.c_msb ^ g_stage[STAGES-1].c_out;
      end
    end
  end

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// tb/tb_rca_pipe_addsub.sv - scoreboard bench for rca_pipe_addsub against an arithmetic reference
module tb_rca_pipe_addsub;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  res_t exp_q[$];
  res_t mon_exp;
  res_t prev;
  bit   prev_stall = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rca_pipe_addsub #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic sb);
    int   ux, uy, sx, sy, cc, ru, rs;
    res_t r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    cc = c ? 1 : 0;
    if (!sb) begin
      ru   = ux + uy + cc;
      rs   = sx + sy + cc;
      r.co = (ru >= (1 << W));
    end else begin
      ru   = ux - uy - cc;
      rs   = sx - sy - cc;
      r.co = (ru >= 0);
    end
    r.s   = ru[W-1:0];
    r.ovf = (rs > ((1 << (W - 1)) - 1)) || (rs < -(1 << (W - 1)));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else if (mon_en) begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", {s, co, ovf}, prev);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got s=%h co=%b ovf=%b exp=none", s, co, ovf);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("s", s, mon_exp.s);
          chk("co", co, mon_exp.co);
          chk("ovf", ovf, mon_exp.ovf);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev       = {s, co, ovf};
    end
  end

  task automatic dir(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                     input logic sb, input res_t e);
    int lat;
    @(negedge clk);
    a = x; b = y; ci = c; sub = sb;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("dir_in_ready", in_ready, 1);
    if (in_ready) exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    chk("latency", lat, 4);
  endtask

  task automatic rand_phase(input int n, input bit toggle);
    int sent = 0;
    int cyc = 0;
    while (sent < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      out_ready = toggle ? ~out_ready : 1'($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      a   = W'($urandom);
      b   = W'($urandom);
      ci  = 1'($urandom);
      sub = 1'($urandom);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, ci, sub));
        sent++;
      end
    end
    chk("rand_sent", sent, n);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      out_ready = toggle ? ~out_ready : 1'($urandom_range(0, 1));
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

    dir(16'h00FF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0100, co: 1'b0, ovf: 1'b0});
    dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, co: 1'b1, ovf: 1'b0});
    dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h8000, co: 1'b0, ovf: 1'b1});
    dir(16'h0005, 16'h0007, 1'b0, 1'b1, '{s: 16'hFFFE, co: 1'b0, ovf: 1'b0});
    dir(16'h8000, 16'h0001, 1'b0, 1'b1, '{s: 16'h7FFF, co: 1'b1, ovf: 1'b1});
    dir(16'h0010, 16'h0001, 1'b1, 1'b1, '{s: 16'h000E, co: 1'b1, ovf: 1'b0});

    rand_phase(16, 1'b1);
    rand_phase(200, 1'b0);

    // Three beats in flight, then a one-cycle reset must discard them all
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      ci = 1'b0;
      sub = 1'b0;
      #1;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("flush_out_valid", out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale", out_valid, 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
